// File: rtl/inst_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_queue_pkg
// This package holds the shared definitions for the instruction queue slice:
//   InstSize / REGSize  width of an instruction word and of a register value
//   one / zero          1-bit constants used by the surrounding codebase
//   IQ_DEPTH, IQ_ADDR_W default queue depth and pointer width
//   iq_entry_t          packed {inst, pc} entry of 2*InstSize bits
// ---------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int   InstSize  = 32;
    localparam int   REGSize   = 32;
    localparam logic one       = 1'b1;
    localparam logic zero      = 1'b0;
    localparam int   IQ_DEPTH  = 16;
    localparam int   IQ_ADDR_W = 4;

    typedef struct packed {
        logic [InstSize-1:0] inst;
        logic [InstSize-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_mem.sv
// ---------------------------------------------------------------------------
// iq_mem
// This module is the instruction queue storage: a DEPTH x W register array.
// It has one synchronous write port and one asynchronous read port. The
// storage is not reset.
//   clk_in      write clock
//   we          write enable
//   waddr/wdata write address and data
//   raddr       read address
//   rdata       read data, combinational from raddr
// ---------------------------------------------------------------------------
module iq_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 64
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
// This module is a circular instruction FIFO that sits between fetch (IF) and
// decode/dispatch. The oldest entry is shown ahead at the output under a
// valid/ready handshake.
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global ready; low freezes the queue
//   clear                     synchronous flush (ROB mispredict)
//   Inst_Status_in, Inst_in,
//   pc_in                     push strobe and payload from IF
//   IQ_isfull                 back-pressure to IF (asserted at DEPTH-1)
//   dispatch_ready_in         dispatch accepts the head this cycle
//   inst_valid_out, inst_out,
//   pc_out                    head entry
//   count_out                 occupancy 0..DEPTH
//   ovf_err_out               sticky: push seen while full with no pop
// ---------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int ADDR_W = IQ_ADDR_W,
    parameter int INST_W = InstSize
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              Inst_Status_in,
    input  logic [INST_W-1:0] Inst_in,
    input  logic [INST_W-1:0] pc_in,
    output logic              IQ_isfull,
    input  logic              dispatch_ready_in,
    output logic              inst_valid_out,
    output logic [INST_W-1:0] inst_out,
    output logic [INST_W-1:0] pc_out,
    output logic [ADDR_W:0]   count_out,
    output logic              ovf_err_out
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
    } entry_t;

    localparam logic [ADDR_W:0]   FULL_CNT   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ALMOST_CNT = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] head, tail;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              push_req, push, pop, ovf_evt;
    entry_t            wr_entry, rd_entry;

    // Head output: registers only, no bypass from Inst_in.
    assign inst_valid_out = (count != '0) && rdy_in && !clear;
    assign pop            = inst_valid_out && dispatch_ready_in;

    // A push at full is only legal when the head leaves in the same cycle.
    assign push_req = Inst_Status_in && rdy_in && !clear;
    assign push     = push_req && ((count < FULL_CNT) || pop);
    assign ovf_evt  = push_req && (count == FULL_CNT) && !pop;

    // One entry of slack: IF's push strobe is registered, so it may already be
    // pushing in the cycle it first sees full.
    assign IQ_isfull   = (count >= ALMOST_CNT);
    assign count_out   = count;
    assign ovf_err_out = ovf;

    assign wr_entry.inst = Inst_in;
    assign wr_entry.pc   = pc_in;
    assign inst_out      = rd_entry.inst;
    assign pc_out        = rd_entry.pc;

    iq_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (2*INST_W)
    ) u_mem (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (tail),
        .wdata  (wr_entry),
        .raddr  (head),
        .rdata  (rd_entry)
    );

    // Full and empty are told apart only by count; pointers wrap on their own.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (ovf_evt) ovf <= 1'b1;
        end
    end

endmodule
